// File: rtl/control_arb.sv
// rtl/control_arb.sv - round-robin arbiter granting one of four requesters a shared resource with timeout
module control_arb #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         iClock,
    input  logic         iReset,
    input  logic [3:0]   iReq,
    input  logic [127:0] iCmd,
    input  logic         iDone,
    output logic [3:0]   oGrant,
    output logic [31:0]  oCmd,
    output logic         oCmdValid,
    output logic         oTimeout,
    output logic [15:0]  oCount,
    output logic         oPaseePorReset
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RELEASE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  win_q, win_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  grant_q, grant_d;
    logic [31:0] cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        timeout_q, timeout_d;
    logic [15:0] count_q, count_d;
    logic        por_q, por_d;

    logic [1:0]  rr_idx;
    logic [1:0]  rr_cand;
    logic        rr_hit;

    // First requester at or after ptr+1, wrapping; ptr itself is checked last.
    always_comb begin
        rr_idx  = ptr_q;
        rr_cand = '0;
        rr_hit  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rr_cand = ptr_q + 2'(i);
            if (!rr_hit && iReq[rr_cand]) begin
                rr_idx = rr_cand;
                rr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        wait_cnt_d  = wait_cnt_q;
        grant_d     = grant_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        timeout_d   = 1'b0;
        count_d     = count_q;
        por_d       = 1'b1;
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (rr_hit) begin
                    state_d     = S_GRANT;
                    win_d       = rr_idx;
                    grant_d     = 4'b0001 << rr_idx;
                    cmd_d       = iCmd[{rr_idx, 5'b0} +: 32];
                    cmd_valid_d = 1'b1;
                end
            end
            S_GRANT: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (iDone) begin
                    state_d = S_RELEASE;
                    grant_d = '0;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = S_RELEASE;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_RELEASE: begin
                state_d    = S_IDLE;
                ptr_d      = win_q;
                wait_cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q     <= S_IDLE;
            ptr_q       <= 2'd3;
            win_q       <= '0;
            wait_cnt_q  <= '0;
            grant_q     <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            count_q     <= '0;
            por_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            wait_cnt_q  <= wait_cnt_d;
            grant_q     <= grant_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            timeout_q   <= timeout_d;
            count_q     <= count_d;
            por_q       <= por_d;
        end
    end

    assign oGrant         = grant_q;
    assign oCmd           = cmd_q;
    assign oCmdValid      = cmd_valid_q;
    assign oTimeout       = timeout_q;
    assign oCount         = count_q;
    assign oPaseePorReset = por_q;

endmodule

// File: tb/tb_control_arb.sv
// tb/tb_control_arb.sv - scoreboard bench for control_arb
module tb_control_arb;

    localparam int TO = 16;

    logic         iClock = 1'b0;
    logic         iReset;
    logic [3:0]   iReq;
    logic [127:0] iCmd;
    logic         iDone;
    logic [3:0]   oGrant;
    logic [31:0]  oCmd;
    logic         oCmdValid;
    logic         oTimeout;
    logic [15:0]  oCount;
    logic         oPaseePorReset;

    control_arb #(.TIMEOUT_CYCLES(TO)) dut (
        .iClock(iClock), .iReset(iReset), .iReq(iReq), .iCmd(iCmd), .iDone(iDone),
        .oGrant(oGrant), .oCmd(oCmd), .oCmdValid(oCmdValid), .oTimeout(oTimeout),
        .oCount(oCount), .oPaseePorReset(oPaseePorReset)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        int          idx;
        logic [31:0] cmd;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          timeouts_seen = 0;
    int          m_ptr = 3;
    int          exp_count = 0;
    int          lat;
    logic [31:0] cmd_tab [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    function automatic int rr(input logic [3:0] req, input int ptr);
        for (int i = 1; i <= 4; i++) begin
            if (req[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic push_exp(input logic [3:0] req);
        int w;
        w = rr(req, m_ptr);
        sb.push_back('{w, cmd_tab[w]});
        m_ptr = w;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (oCmdValid === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("grant_wait", 32'd0, 32'd1);
    endtask

    task automatic finish_txn(input int delay);
        repeat (delay) step();
        iDone = 1'b1;
        step();
        iDone = 1'b0;
        exp_count++;
        chk("count", 32'(oCount), 32'(exp_count));
        chk("release_grant", 32'(oGrant), 32'd0);
        chk("no_timeout", 32'(oTimeout), 32'd0);
        step();
    endtask

    always @(negedge iClock) begin
        if (iReset === 1'b1 && oTimeout === 1'b1) timeouts_seen++;
        if (iReset === 1'b1 && oCmdValid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("grant", 32'(oGrant), 32'(4'b0001 << mon_e.idx));
                chk("cmd", oCmd, mon_e.cmd);
            end
        end
    end

    initial begin
        for (int n = 0; n < 4; n++) cmd_tab[n] = 32'hA0A0_0000 + 32'(n);
        iCmd   = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};
        iReset = 1'b0;
        iReq   = 4'h0;
        iDone  = 1'b0;

        for (int i = 0; i < 25; i++) begin
            step();
            chk("rst_ctl", 32'({oGrant, oCmdValid, oTimeout, oPaseePorReset}), 32'd0);
            chk("rst_cmd", oCmd, 32'd0);
            chk("rst_cnt", 32'(oCount), 32'd0);
        end
        iReset = 1'b1;
        step();
        chk("por", 32'(oPaseePorReset), 32'd1);
        step();
        chk("por_hold", 32'(oPaseePorReset), 32'd1);
        chk("idle_grant", 32'(oGrant), 32'd0);

        iReq = 4'hF;
        for (int k = 0; k < 5; k++) begin
            push_exp(4'hF);
            wait_valid();
            finish_txn(2);
        end
        iReq = 4'h0;
        chk("count5", 32'(oCount), 32'd5);

        iReq = 4'b0100;
        push_exp(4'b0100);
        wait_valid();
        lat = 0;
        for (int i = 0; i < 40 && oTimeout !== 1'b1; i++) begin
            step();
            lat++;
        end
        chk("timeout_lat", 32'(lat), 32'(TO + 1));
        chk("timeout_grant", 32'(oGrant), 32'd0);
        chk("timeout_count", 32'(oCount), 32'(exp_count));
        step();
        chk("timeout_pulse", 32'(oTimeout), 32'd0);
        chk("timeouts_seen", 32'(timeouts_seen), 32'd1);
        push_exp(4'b0100);
        wait_valid();
        finish_txn(2);

        push_exp(4'b0100);
        wait_valid();
        finish_txn(TO);
        chk("coincide_no_to", 32'(timeouts_seen), 32'd1);

        iReq = 4'b0010;
        push_exp(4'b0010);
        wait_valid();
        step();
        iReq = 4'h0;
        iCmd[63:32] = 32'hDEAD_BEEF;
        repeat (3) step();
        chk("cmd_hold", oCmd, cmd_tab[1]);
        chk("grant_hold", 32'(oGrant), 32'b0010);
        finish_txn(1);
        iCmd = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};

        iReq = 4'b1000;
        push_exp(4'b1000);
        wait_valid();
        step();
        step();
        iReset = 1'b0;
        step();
        chk("rst_mid_grant", 32'(oGrant), 32'd0);
        chk("rst_mid_count", 32'(oCount), 32'd0);
        chk("rst_mid_por", 32'(oPaseePorReset), 32'd0);
        step();
        chk("rst_mid_to", 32'(oTimeout), 32'd0);
        iReset = 1'b1;
        iReq = 4'hF;
        m_ptr = 3;
        exp_count = 0;
        push_exp(4'hF);
        wait_valid();
        chk("por_again", 32'(oPaseePorReset), 32'd1);
        finish_txn(2);
        iReq = 4'h0;
        step();
        chk("final_timeouts", 32'(timeouts_seen), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
